// File: rtl/mult_pkg.sv
// Shared widths and operand/product types for the pipelined 16x16 multiplier.
package mult_pkg;

    localparam int unsigned MULT_WIDTH   = 16;
    localparam int unsigned MULT_PWIDTH  = 32;
    localparam int unsigned MULT_LATENCY = 3;

    typedef logic [MULT_WIDTH-1:0]  operand_t;
    typedef logic [MULT_PWIDTH-1:0] product_t;

endpackage

// File: rtl/csa_3to2.sv
// Carry-save 3:2 compressor: x+y+z == sum+carry (modulo 2^W).
module csa_3to2
    import mult_pkg::*;
#(
    parameter int unsigned W = MULT_PWIDTH
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    always_comb begin
        sum   = x ^ y ^ z;
        maj   = (x & y) | (x & z) | (y & z);
        carry = maj << 1;
    end

endmodule

// File: rtl/multiplier_16bit.sv
// Three-stage pipelined unsigned 16x16->32 multiplier: operand register,
// carry-save partial-product reduction, final carry-propagate add.
module multiplier_16bit
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P
);

    operand_t a_d, a_q;
    operand_t b_d, b_q;
    product_t sum_d, sum_q;
    product_t carry_d, carry_q;
    product_t p_d, p_q;

    // Reduction tree rows per level: 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2
    product_t l0 [16];
    product_t l1 [11];
    product_t l2 [8];
    product_t l3 [6];
    product_t l4 [4];
    product_t l5 [3];
    product_t l6 [2];

    always_comb begin
        for (int unsigned i = 0; i < MULT_WIDTH; i++) begin
            l0[i] = b_q[i] ? (product_t'(a_q) << i) : '0;
        end
    end

    for (genvar k = 0; k < 5; k++) begin : g_l1
        csa_3to2 #(.W(MULT_PWIDTH)) u_csa (
            .x(l0[3*k]), .y(l0[3*k+1]), .z(l0[3*k+2]),
            .sum(l1[2*k]), .carry(l1[2*k+1])
        );
    end
    assign l1[10] = l0[15];

    for (genvar k = 0; k < 3; k++) begin : g_l2
        csa_3to2 #(.W(MULT_PWIDTH)) u_csa (
            .x(l1[3*k]), .y(l1[3*k+1]), .z(l1[3*k+2]),
            .sum(l2[2*k]), .carry(l2[2*k+1])
        );
    end
    assign l2[6] = l1[9];
    assign l2[7] = l1[10];

    for (genvar k = 0; k < 2; k++) begin : g_l3
        csa_3to2 #(.W(MULT_PWIDTH)) u_csa (
            .x(l2[3*k]), .y(l2[3*k+1]), .z(l2[3*k+2]),
            .sum(l3[2*k]), .carry(l3[2*k+1])
        );
    end
    assign l3[4] = l2[6];
    assign l3[5] = l2[7];

    for (genvar k = 0; k < 2; k++) begin : g_l4
        csa_3to2 #(.W(MULT_PWIDTH)) u_csa (
            .x(l3[3*k]), .y(l3[3*k+1]), .z(l3[3*k+2]),
            .sum(l4[2*k]), .carry(l4[2*k+1])
        );
    end

    csa_3to2 #(.W(MULT_PWIDTH)) u_csa_l5 (
        .x(l4[0]), .y(l4[1]), .z(l4[2]),
        .sum(l5[0]), .carry(l5[1])
    );
    assign l5[2] = l4[3];

    csa_3to2 #(.W(MULT_PWIDTH)) u_csa_l6 (
        .x(l5[0]), .y(l5[1]), .z(l5[2]),
        .sum(l6[0]), .carry(l6[1])
    );

    always_comb begin
        a_d     = A;
        b_d     = B;
        sum_d   = l6[0];
        carry_d = l6[1];
        p_d     = sum_q + carry_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            p_q     <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            p_q     <= p_d;
        end
    end

    assign P = p_q;

endmodule

// File: tb/tb_multiplier_16bit.sv
// Directed and scoreboard tests for multiplier_16bit (2-edge sample-to-output delay).
module tb_multiplier_16bit;

    logic        CLK;
    logic        RST_N;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] P;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Products sampled one and two edges ago
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;

    multiplier_16bit #(.WIDTH(16)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .A    (A),
        .B    (B),
        .P    (P)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input logic [15:0] a, input logic [15:0] b, output logic [31:0] exp);
        A = a;
        B = b;
        @(posedge CLK);
        #1;
        exp = d2;
        d2  = d1;
        d1  = {16'h0, a} * {16'h0, b};
        if (!RST_N) begin
            exp = '0;
            d1  = '0;
            d2  = '0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        logic [31:0] want [3];
        want[0] = 32'h0000_0000;
        want[1] = 32'h0000_0000;
        want[2] = 32'h0626_0060;
        RST_N = 1'b0;
        #1;
        total++;
        if (P !== 32'h0) begin
            bad++;
            $display("FAIL reset_assert: P=%h want %h", P, 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            tick(16'h1234, 16'h5678, exp);
            total++;
            if (P !== 32'h0) begin
                bad++;
                $display("FAIL reset_hold[%0d]: P=%h want %h", i, P, 32'h0);
            end
        end
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(16'h1234, 16'h5678, exp);
            total++;
            if (P !== want[i]) begin
                bad++;
                $display("FAIL reset_release[%0d]: P=%h want %h", i, P, want[i]);
            end
        end
    endtask

    task automatic test_corners();
        logic [31:0] exp;
        logic [15:0] av [6];
        logic [15:0] bv [6];
        logic [31:0] want [6];
        av[0] = 16'hFFFF; bv[0] = 16'hFFFF;
        av[1] = 16'hFFFF; bv[1] = 16'h0001;
        av[2] = 16'h0000; bv[2] = 16'hABCD;
        av[3] = 16'h8000; bv[3] = 16'h8000;
        av[4] = 16'h0000; bv[4] = 16'h0000;
        av[5] = 16'h0000; bv[5] = 16'h0000;
        want[0] = 32'h0626_0060;
        want[1] = 32'h0626_0060;
        want[2] = 32'hFFFE_0001;
        want[3] = 32'h0000_FFFF;
        want[4] = 32'h0000_0000;
        want[5] = 32'h4000_0000;
        for (int i = 0; i < 6; i++) begin
            tick(av[i], bv[i], exp);
            total++;
            if (P !== want[i]) begin
                bad++;
                $display("FAIL corner[%0d]: P=%h want %h", i, P, want[i]);
            end
        end
    endtask

    task automatic test_ramp();
        logic [31:0] exp;
        logic [15:0] a;
        logic [15:0] b;
        a = 16'h0000;
        b = 16'h0000;
        for (int i = 0; i < 500; i++) begin
            tick(a, b, exp);
            total++;
            if (P !== exp) begin
                bad++;
                $display("FAIL ramp[%0d]: P=%h want %h", i, P, exp);
            end
            a = a + 16'd1;
            if (((i / 5) % 2) == 0) b = b + 16'd1;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        logic [15:0] a;
        logic [15:0] b;
        a = 16'hFFF8;
        b = 16'hFFF0;
        for (int i = 0; i < 16; i++) begin
            tick(a, b, exp);
            total++;
            if (P !== exp) begin
                bad++;
                $display("FAIL wrap[%0d]: P=%h want %h", i, P, exp);
            end
            a = a + 16'd1;
            b = b + 16'd1;
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp;
        logic [15:0] a;
        logic [15:0] b;
        a = 16'h0100;
        b = 16'h0200;
        for (int i = 0; i < 8; i++) begin
            tick(a, b, exp);
            total++;
            if (P !== exp) begin
                bad++;
                $display("FAIL pre_reset[%0d]: P=%h want %h", i, P, exp);
            end
            a = a + 16'd1;
            b = b + 16'd1;
        end
        #3;
        RST_N = 1'b0;
        #1;
        total++;
        if (P !== 32'h0) begin
            bad++;
            $display("FAIL async_reset_now: P=%h want %h", P, 32'h0);
        end
        d1 = '0;
        d2 = '0;
        for (int i = 0; i < 2; i++) begin
            tick(a, b, exp);
            total++;
            if (P !== 32'h0) begin
                bad++;
                $display("FAIL async_reset_hold[%0d]: P=%h want %h", i, P, 32'h0);
            end
        end
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(a, b, exp);
            total++;
            if (P !== exp) begin
                bad++;
                $display("FAIL post_reset[%0d]: P=%h want %h", i, P, exp);
            end
            a = a + 16'd1;
            b = b + 16'd1;
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        logic [15:0] a;
        logic [15:0] b;
        for (int i = 0; i < 10000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            tick(a, b, exp);
            total++;
            if (P !== exp) begin
                bad++;
                $display("FAIL random[%0d]: P=%h want %h", i, P, exp);
            end
        end
    endtask

    initial begin
        RST_N = 1'b1;
        A     = '0;
        B     = '0;
        #2;
        test_reset();
        test_corners();
        test_ramp();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
